// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative integer square-root block:
// state encodings and the default radicand width.
package sqrt_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b11
    } sqrt_state_t;

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root digit step: bring in the next radicand bit pair,
// try to subtract (4*root + 1), and append the resulting root bit.
module sqrt_step #(
    parameter int RW = 8
) (
    input  logic [RW+1:0] rem,
    input  logic [RW-1:0] root,
    input  logic [1:0]    pair,
    output logic [RW+1:0] rem_next,
    output logic [RW-1:0] root_next
);

    logic [RW+1:0] rem_sh;
    logic [RW+1:0] trial;
    logic          fits;

    // RW+2 bits hold both operands: before the final step the partial root has
    // at most RW-1 significant bits and the remainder at most RW.
    always_comb begin
        rem_sh    = (rem << 2) | {{RW{1'b0}}, pair};
        trial     = ({2'b00, root} << 2) | {{(RW+1){1'b0}}, 1'b1};
        fits      = (rem_sh >= trial);
        rem_next  = fits ? (rem_sh - trial) : rem_sh;
        root_next = (root << 1) | {{(RW-1){1'b0}}, fits};
    end

endmodule

// File: rtl/sqrt_iter.sv
// Iterative unsigned integer square root: one root bit per clock, RW = WIDTH/2
// steps per result, with abort and zero-bubble back-to-back operation.
module sqrt_iter
    import sqrt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [WIDTH-1:0]  radicand_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [WIDTH/2-1:0] root_o,
    output logic [WIDTH/2:0]   rem_o
);

    localparam int RW = WIDTH / 2;
    localparam int CW = $clog2(RW);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("sqrt_iter: WIDTH must be even and at least 4");
        end
    endgenerate

    sqrt_state_t   state;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] rad_q;
    logic [RW-1:0] root_q;
    logic [RW+1:0] rem_q;

    logic [RW+1:0] rem_next;
    logic [RW-1:0] root_next;

    sqrt_step #(
        .RW (RW)
    ) u_step (
        .rem       (rem_q),
        .root      (root_q),
        .pair      (rad_q[WIDTH-1:WIDTH-2]),
        .rem_next  (rem_next),
        .root_next (root_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            rad_q  <= '0;
            root_q <= '0;
            rem_q  <= '0;
            root_o <= '0;
            rem_o  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        rad_q  <= radicand_i;
                        root_q <= '0;
                        rem_q  <= '0;
                        cnt    <= CW'(RW - 1);
                        state  <= S_CALC;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_CALC: begin
                    // Abort beats any start seen in the same cycle.
                    if (abort_i) begin
                        state  <= S_IDLE;
                        root_o <= '0;
                        rem_o  <= '0;
                    end else begin
                        root_q <= root_next;
                        rem_q  <= rem_next;
                        rad_q  <= rad_q << 2;
                        cnt    <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state  <= S_DONE;
                            root_o <= root_next;
                            rem_o  <= rem_next[RW:0];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready_o = (state == S_IDLE) || (state == S_DONE);
    assign busy_o  = (state == S_CALC);
    assign done_o  = (state == S_DONE);

endmodule

// File: tb/tb_sqrt_iter.sv
// Directed bench for sqrt_iter: a 16-bit instance for latency, back-to-back,
// abort, start-hold and reset cases, plus an exhaustive sweep of an 8-bit one.
module tb_sqrt_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start16 = 1'b0, abort16 = 1'b0;
    logic [15:0] rad16 = '0;
    logic        ready16, busy16, done16;
    logic [7:0]  root16;
    logic [8:0]  rem16;

    logic        start8 = 1'b0, abort8 = 1'b0;
    logic [7:0]  rad8 = '0;
    logic        ready8, busy8, done8;
    logic [3:0]  root8;
    logic [4:0]  rem8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sqrt_iter #(.WIDTH(16)) u16 (
        .clk (clk), .rst (rst), .start_i (start16), .abort_i (abort16),
        .radicand_i (rad16), .ready_o (ready16), .busy_o (busy16),
        .done_o (done16), .root_o (root16), .rem_o (rem16)
    );

    sqrt_iter #(.WIDTH(8)) u8 (
        .clk (clk), .rst (rst), .start_i (start8), .abort_i (abort8),
        .radicand_i (rad8), .ready_o (ready8), .busy_o (busy8),
        .done_o (done8), .root_o (root8), .rem_o (rem8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the following posedge is the start edge.
    task automatic op16(input logic [15:0] v, input int er, input int erem,
                        input bit hold, input bit with_abort, input string tag);
        int n;
        start16 = 1'b1;
        rad16   = v;
        abort16 = with_abort;
        @(negedge clk);
        chk({tag, "_busy"}, 32'(busy16), 1);
        abort16 = 1'b0;
        if (hold) rad16 = 16'hFFFF;
        else      start16 = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done16) break;
            if (hold) rad16 = 16'(v + 16'(n * 37 + 1));
        end
        chk({tag, "_latency"}, 32'(n), 8);
        chk({tag, "_done"},  32'(done16), 1);
        chk({tag, "_root"},  32'(root16), 32'(er));
        chk({tag, "_rem"},   32'(rem16), 32'(erem));
        chk({tag, "_ready"}, 32'(ready16), 1);
        start16 = 1'b0;
    endtask

    task automatic op8(input logic [7:0] v, output int lat);
        int n;
        start8 = 1'b1;
        rad8   = v;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (done8) break;
        end
        lat = n;
    endtask

    initial begin
        int lat, dones, r;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", 32'(ready16), 1);
        chk("reset_busy",  32'(busy16), 0);
        chk("reset_done",  32'(done16), 0);
        chk("reset_root",  32'(root16), 0);
        chk("reset_rem",   32'(rem16), 0);

        op16(16'd144, 12, 0, 1'b0, 1'b0, "r144");
        // Back-to-back: each call starts in the DONE cycle of the previous one.
        op16(16'd0,     0,   0,   1'b0, 1'b0, "b2b_0");
        op16(16'd145,   12,  1,   1'b0, 1'b0, "b2b_145");
        op16(16'd65535, 255, 510, 1'b0, 1'b0, "b2b_65535");
        @(negedge clk);
        chk("after_done_pulse", 32'(done16), 0);
        chk("after_done_ready", 32'(ready16), 1);
        chk("hold_root", 32'(root16), 255);
        chk("hold_rem",  32'(rem16), 510);

        // Abort mid-calculation, with a competing start in the same cycle.
        start16 = 1'b1;
        rad16   = 16'd1000;
        @(negedge clk);
        start16 = 1'b0;
        repeat (3) @(negedge clk);
        abort16 = 1'b1;
        start16 = 1'b1;
        @(negedge clk);
        abort16 = 1'b0;
        start16 = 1'b0;
        chk("abort_ready", 32'(ready16), 1);
        chk("abort_busy",  32'(busy16), 0);
        chk("abort_done",  32'(done16), 0);
        chk("abort_root",  32'(root16), 0);
        chk("abort_rem",   32'(rem16), 0);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done16) dones++;
        end
        chk("abort_no_done", 32'(dones), 0);
        abort16 = 1'b1;
        @(negedge clk);
        abort16 = 1'b0;
        chk("abort_idle_ready", 32'(ready16), 1);

        op16(16'd99, 9, 18, 1'b1, 1'b0, "hold99");

        // Reset in the middle of a calculation.
        start16 = 1'b1;
        rad16   = 16'd500;
        @(negedge clk);
        start16 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        start16 = 1'b1;
        abort16 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start16 = 1'b0;
        abort16 = 1'b0;
        chk("midrst_ready", 32'(ready16), 1);
        chk("midrst_busy",  32'(busy16), 0);
        chk("midrst_done",  32'(done16), 0);
        chk("midrst_root",  32'(root16), 0);
        chk("midrst_rem",   32'(rem16), 0);
        // Start accepted from IDLE even with abort asserted alongside it.
        op16(16'd4, 2, 0, 1'b0, 1'b1, "r4");

        @(negedge clk);
        op8(8'd255, lat);
        chk("w8_latency", 32'(lat), 4);
        chk("w8_root255", 32'(root8), 15);
        chk("w8_rem255",  32'(rem8), 30);
        for (int v = 0; v < 256; v++) begin
            op8(8'(v), lat);
            r = 0;
            while ((r + 1) * (r + 1) <= v) r++;
            chk("w8_sweep_root", 32'(root8), 32'(r));
            chk("w8_sweep_rem",  32'(rem8), 32'(v - r * r));
            chk("w8_sweep_done", 32'(done8), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
